// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   // Native word width of a queued entry (instruction and PC fields).
   localparam int unsigned FETCH_XLEN = 32;

   // Byte size of one instruction; PC stride between sequential fetches.
   localparam int unsigned INSTR_SIZE = 4;

   // Next-PC source select driven by the execute stage; 2'b11 is reserved.
   typedef enum logic [1:0] {
      PCSRC_SEQ  = 2'b00,
      PCSRC_BR   = 2'b01,
      PCSRC_JALR = 2'b10
   } pcsrc_e;

   // One prefetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
   } fetch_entry_t;

   // A redirect is a taken branch or a jalr; anything else falls through.
   function automatic logic is_redirect(input logic [1:0] src);
      return (src == PCSRC_BR) || (src == PCSRC_JALR);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions sitting between memory and decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  fetch_entry_t     din,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // Next-state: clear wins; otherwise a push into a full queue is only
   // accepted when a pop frees a slot in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // State registers; storage is zeroed on reset so the head reads 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: PC generation, redirect handling and prefetch queue
// decoupling a pipelined, handshaked instruction memory from decode.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              QUEUE_DEPTH   = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               PCSrc,
   input  logic [ADDRESS_WIDTH-1:0] PCE,
   input  logic [DATA_WIDTH-1:0]    ImmExt,
   input  logic [DATA_WIDTH-1:0]    ALUResult,
   input  logic                     stall,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic [DATA_WIDTH-1:0]    InstrD,
   output logic [ADDRESS_WIDTH-1:0] PCD,
   output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
   output logic                     ValidD
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(INSTR_SIZE);

   logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]         outstanding_q, outstanding_d;
   logic [CNT_W-1:0]         discard_q, discard_d;
   logic [ADDRESS_WIDTH-1:0] target;
   logic [CNT_W:0]           occupancy;
   logic                     redirect;
   logic                     req_fire;
   logic                     resp_fire;
   logic                     q_push;
   logic                     q_pop;
   logic                     q_empty;
   logic                     q_full;
   logic [CNT_W-1:0]         q_count;
   fetch_entry_t             q_din;
   fetch_entry_t             q_head;

   assign redirect  = is_redirect(PCSrc);
   // Responses with nothing outstanding (e.g. straggling across a reset) are ignored.
   assign resp_fire = imem_rvalid && (outstanding_q != '0);
   // Queued plus in-flight entries never exceed the queue size, so no overflow.
   assign occupancy = {1'b0, q_count} + {1'b0, outstanding_q};
   assign imem_req  = !rst && !redirect && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
   assign imem_addr = fetch_pc_q;
   assign req_fire  = imem_req && imem_gnt;
   assign q_push    = resp_fire && !redirect && (discard_q == '0);
   assign q_pop     = !q_empty && !stall;

   // Redirect target; bit0 of a jalr target and bits[1:0] of any target are forced low.
   always_comb begin
      target = '0;
      case (PCSrc)
         PCSRC_BR:   target = PCE + ADDRESS_WIDTH'(ImmExt);
         PCSRC_JALR: target = ADDRESS_WIDTH'(ALUResult);
         default:    target = '0;
      endcase
      target[1:0] = 2'b00;
   end

   // Entry written into the queue on an accepted response.
   always_comb begin
      q_din       = '0;
      q_din.instr = FETCH_XLEN'(imem_rdata);
      q_din.pc    = FETCH_XLEN'(resp_pc_q);
   end

   // Next PC / counter state; a redirect discards everything still in flight.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      if (redirect) begin
         fetch_pc_d    = target;
         resp_pc_d     = target;
         // outstanding already includes any stale responses still pending.
         outstanding_d = outstanding_q - CNT_W'(resp_fire);
         discard_d     = outstanding_q - CNT_W'(resp_fire);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
         if (resp_fire) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CNT_W'(1);
            end else begin
               resp_pc_d = resp_pc_q + STEP;
            end
         end
      end
   end

   // PC and in-flight bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // Guards the issue gate: an accepted response must always find a free slot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(q_push && q_full && !q_pop));
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .pop   (q_pop),
      .clear (redirect),
      .din   (q_din),
      .count (q_count),
      .empty (q_empty),
      .full  (q_full),
      .head  (q_head)
   );

   // Decode-facing outputs read zero whenever the head is not valid.
   assign ValidD   = !q_empty;
   assign InstrD   = ValidD ? DATA_WIDTH'(q_head.instr) : '0;
   assign PCD      = ValidD ? ADDRESS_WIDTH'(q_head.pc) : '0;
   assign PCPlus4D = ValidD ? ADDRESS_WIDTH'(q_head.pc) + STEP : '0;

endmodule
